// File: rtl/sr_ram_arbiter.sv
// Two-port (local CPU / NoC) round-robin arbiter in front of a single-ported RAM chunk.
// Stores complete in one cycle; loads are returned 2 cycles after their grant.
module sr_ram_arbiter #(
   parameter int unsigned RAM_CHUNK_SIZE = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       reqValid,
   input  logic [1:0]       reqWe,
   input  logic [1:0][31:0] reqAddr,
   input  logic [1:0][31:0] reqWData,
   output logic [1:0]       gnt,
   output logic [1:0]       err,
   output logic [1:0]       rValid,
   output logic [31:0]      rData,
   output logic [31:0]      ramAddress,
   output logic [31:0]      wrData,
   output logic             we,
   input  logic [31:0]      rdData
);

   localparam logic [31:0] CHUNK_LIMIT = 32'(RAM_CHUNK_SIZE);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        last_winner_q, last_winner_d;
   logic        owner_q, owner_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  err_q, err_d;
   logic [1:0]  rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] ram_addr_q, ram_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        we_q, we_d;

   logic [1:0]  req_m_s;
   logic        any_s;
   logic        win_s;
   logic [31:0] win_addr_s;
   logic        in_range_s;
   logic        win_load_s;

   // A side being granted this cycle is still holding reqValid, so it is masked out.
   always_comb begin
      req_m_s = reqValid & ~gnt_q;
      any_s   = |req_m_s;
      if (req_m_s == 2'b11) begin
         win_s = ~last_winner_q;
      end else begin
         win_s = req_m_s[1];
      end
      win_addr_s = reqAddr[win_s];
      in_range_s = (win_addr_s < CHUNK_LIMIT);
      win_load_s = ~reqWe[win_s];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: only an in-range load leaves IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (any_s && in_range_s && win_load_s) begin
               state_d = RD_ADDR;
            end else begin
               state_d = IDLE;
            end
         end
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next values; pulses default low, RAM bus and read data hold.
   always_comb begin
      gnt_d         = 2'b00;
      err_d         = 2'b00;
      rvalid_d      = 2'b00;
      we_d          = 1'b0;
      rdata_d       = rdata_q;
      ram_addr_d    = ram_addr_q;
      wr_data_d     = wr_data_q;
      last_winner_d = last_winner_q;
      owner_d       = owner_q;
      case (state_q)
         IDLE: begin
            if (any_s) begin
               gnt_d[win_s]  = 1'b1;
               last_winner_d = win_s;
               if (!in_range_s) begin
                  err_d[win_s] = 1'b1;
               end else begin
                  ram_addr_d = win_addr_s;
                  if (win_load_s) begin
                     owner_d = win_s;
                  end else begin
                     wr_data_d = reqWData[win_s];
                     we_d      = 1'b1;
                  end
               end
            end else begin
               gnt_d = 2'b00;
            end
         end
         RD_ADDR: begin
            gnt_d = 2'b00;
         end
         RD_DATA: begin
            rvalid_d[owner_q] = 1'b1;
            rdata_d           = rdData;
         end
         default: begin
            gnt_d = 2'b00;
         end
      endcase
   end

   // Output and arbitration-history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q         <= 2'b00;
         err_q         <= 2'b00;
         rvalid_q      <= 2'b00;
         we_q          <= 1'b0;
         rdata_q       <= 32'h0000_0000;
         ram_addr_q    <= 32'h0000_0000;
         wr_data_q     <= 32'h0000_0000;
         last_winner_q <= 1'b1;
         owner_q       <= 1'b0;
      end else begin
         gnt_q         <= gnt_d;
         err_q         <= err_d;
         rvalid_q      <= rvalid_d;
         we_q          <= we_d;
         rdata_q       <= rdata_d;
         ram_addr_q    <= ram_addr_d;
         wr_data_q     <= wr_data_d;
         last_winner_q <= last_winner_d;
         owner_q       <= owner_d;
      end
   end

   assign gnt        = gnt_q;
   assign err        = err_q;
   assign rValid     = rvalid_q;
   assign we         = we_q;
   assign rData      = rdata_q;
   assign ramAddress = ram_addr_q;
   assign wrData     = wr_data_q;

endmodule
